fp_mul_wb_queue: RTL and testbench

FP_MUL_WB_QUEUE -- requirements
Module: fp_mul_wb_queue

---
 rtl/fp_mul_wb_queue.sv | 104 ++++++++++
 tb/tb_fp_mul_wb_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp_mul_wb_queue.sv
// fp_mul_wb_queue: FP multiply result writeback queue with NaN/inf/subnormal classification and sticky flags
module fp_mul_wb_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_valid,
  output logic                      out_ready,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic                      in_fmt,
  input  logic [4:0]                in_rd,
  output logic                      out_wb_valid,
  input  logic                      in_wb_ready,
  output logic [DATA_WIDTH-1:0]     out_wb_data,
  output logic [4:0]                out_wb_rd,
  output logic                      out_wb_fmt,
  output logic [4:0]                out_wb_flags,
  input  logic                      in_flags_clr,
  output logic [4:0]                out_fflags,
  output logic [$clog2(DEPTH):0]    out_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [4:0]            rd_q [DEPTH];
  logic                  fmt_q [DEPTH];
  logic [4:0]            flags_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [4:0]            fflags_q, fflags_d, deq_flags;
  logic [DATA_WIDTH-1:0] cls_data;
  logic [4:0]            cls_flags;
  logic                  enq, deq;
  assign out_ready    = in_rst_n && (count_q < CW'(DEPTH));
  assign out_wb_valid = count_q != '0;
  assign enq          = in_valid && out_ready;
  assign deq          = out_wb_valid && in_wb_ready && in_rst_n;
  assign out_wb_data  = data_q[rptr_q];
  assign out_wb_rd    = rd_q[rptr_q];
  assign out_wb_fmt   = fmt_q[rptr_q];
  assign out_wb_flags = flags_q[rptr_q];
  assign out_fflags   = fflags_q;
  assign out_count    = count_q;
  // flags are {NV,DZ,OF,UF,NX}; DZ can never arise from a multiply result here
  always_comb begin
    cls_data  = in_result;
    cls_flags = '0;
    if (in_fmt) begin
      if (&in_result[62:52] && |in_result[51:0]) begin
        cls_data  = 64'h7FF8000000000000;
        cls_flags = {~in_result[51], 4'b0000};
      end else if (&in_result[62:52]) begin
        cls_flags = 5'b00101;
      end else if (~|in_result[62:52] && |in_result[51:0]) begin
        cls_data  = {in_result[63], 63'b0};
        cls_flags = 5'b00011;
      end
    end else if (~&in_result[63:32]) begin
      cls_data  = 64'hFFFFFFFF7FC00000;
      cls_flags = 5'b10000;
    end else if (&in_result[30:23] && |in_result[22:0]) begin
      cls_data  = 64'hFFFFFFFF7FC00000;
      cls_flags = {~in_result[22], 4'b0000};
    end else if (&in_result[30:23]) begin
      cls_flags = 5'b00101;
    end else if (~|in_result[30:23] && |in_result[22:0]) begin
      cls_data  = {32'hFFFFFFFF, in_result[31], 31'b0};
      cls_flags = 5'b00011;
    end
  end
  always_comb begin
    wptr_d    = wptr_q + AW'(enq);
    rptr_d    = rptr_q + AW'(deq);
    count_d   = count_q + CW'(enq) - CW'(deq);
    deq_flags = deq ? flags_q[rptr_q] : 5'b0;
    fflags_d  = in_flags_clr ? deq_flags : (fflags_q | deq_flags);
  end
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        rd_q[i]    <= '0;
        fmt_q[i]   <= 1'b0;
        flags_q[i] <= '0;
      end
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      if (enq) begin
        data_q[wptr_q]  <= cls_data;
        rd_q[wptr_q]    <= in_rd;
        fmt_q[wptr_q]   <= in_fmt;
        flags_q[wptr_q] <= cls_flags;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_wb_queue.sv
// tb_fp_mul_wb_queue: directed scoreboard bench for fp_mul_wb_queue
module tb_fp_mul_wb_queue;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        f;
    logic [4:0]  fl;
  } ent_t;
  logic        in_clk, in_rst_n, in_valid, out_ready, in_fmt, out_wb_valid, in_wb_ready;
  logic [63:0] in_result, out_wb_data;
  logic [4:0]  in_rd, out_wb_rd, out_wb_flags, out_fflags;
  logic        out_wb_fmt, in_flags_clr;
  logic [2:0]  out_count;
  ent_t        sb[$];
  ent_t        pend;
  logic [4:0]  exp_ff;
  int          checks, errors;

  fp_mul_wb_queue #(.DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .in_result(in_result), .in_fmt(in_fmt), .in_rd(in_rd), .out_wb_valid(out_wb_valid),
    .in_wb_ready(in_wb_ready), .out_wb_data(out_wb_data), .out_wb_rd(out_wb_rd),
    .out_wb_fmt(out_wb_fmt), .out_wb_flags(out_wb_flags), .in_flags_clr(in_flags_clr),
    .out_fflags(out_fflags), .out_count(out_count)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock, updating the scoreboard from the inputs currently driven
  task automatic tick();
    logic dq, eq;
    logic [4:0] df;
    dq = in_rst_n && sb.size() > 0 && in_wb_ready;
    eq = in_rst_n && in_valid && sb.size() < DEPTH;
    df = 5'b0;
    if (dq) begin
      df = sb[0].fl;
      void'(sb.pop_front());
    end
    if (eq) sb.push_back(pend);
    if (!in_rst_n) begin
      sb.delete();
      exp_ff = 5'b0;
    end else exp_ff = in_flags_clr ? df : (exp_ff | df);
    @(posedge in_clk);
    @(negedge in_clk);
    chk("count", 64'(out_count), 64'(sb.size()));
    chk("wb_valid", 64'(out_wb_valid), 64'(sb.size() > 0));
    chk("ready", 64'(out_ready), 64'(in_rst_n && sb.size() < DEPTH));
    chk("fflags", 64'(out_fflags), 64'(exp_ff));
    if (sb.size() > 0) begin
      chk("head_data", out_wb_data, sb[0].d);
      chk("head_rd", 64'(out_wb_rd), 64'(sb[0].rd));
      chk("head_fmt", 64'(out_wb_fmt), 64'(sb[0].f));
      chk("head_flags", 64'(out_wb_flags), 64'(sb[0].fl));
    end
  endtask

  task automatic drive(input logic [63:0] r, input logic f, input logic [4:0] rd,
                       input logic [63:0] ed, input logic [4:0] ef);
    in_valid  = 1'b1;
    in_result = r;
    in_fmt    = f;
    in_rd     = rd;
    pend      = '{d: ed, rd: rd, f: f, fl: ef};
  endtask

  task automatic enq(input logic [63:0] r, input logic f, input logic [4:0] rd,
                     input logic [63:0] ed, input logic [4:0] ef);
    drive(r, f, rd, ed, ef);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0; errors = 0; exp_ff = 5'b0;
    in_rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_fmt = 1'b0; in_rd = '0;
    in_wb_ready = 1'b0; in_flags_clr = 1'b0; pend = '0;
    tick();
    tick();
    chk("rst_data", out_wb_data, 64'h0);
    chk("rst_rd", 64'(out_wb_rd), 64'h0);
    chk("rst_fmt", 64'(out_wb_fmt), 64'h0);
    chk("rst_flags", 64'(out_wb_flags), 64'h0);
    in_rst_n = 1'b1;
    // single DP normal, immediate drain
    in_wb_ready = 1'b1;
    enq(64'h4008000000000000, 1'b1, 5'd7, 64'h4008000000000000, 5'b00000);
    chk("dp3_valid", 64'(out_wb_valid), 64'h1);
    chk("dp3_data", out_wb_data, 64'h4008000000000000);
    chk("dp3_rd", 64'(out_wb_rd), 64'd7);
    idle(1);
    chk("dp3_gone", 64'(out_wb_valid), 64'h0);
    // improperly boxed SP becomes canonical NaN with NV
    enq(64'h000000003F800000, 1'b0, 5'd3, 64'hFFFFFFFF7FC00000, 5'b10000);
    chk("sp_box_data", out_wb_data, 64'hFFFFFFFF7FC00000);
    idle(1);
    chk("sp_box_fflags", 64'(out_fflags), 64'(5'b10000));
    in_flags_clr = 1'b1;
    tick();
    chk("fflags_clr", 64'(out_fflags), 64'h0);
    in_flags_clr = 1'b0;
    // DP subnormals flush to signed zero
    in_wb_ready = 1'b0;
    enq(64'h000FFFFFFFFFFFFF, 1'b1, 5'd1, 64'h0000000000000000, 5'b00011);
    enq(64'h800FFFFFFFFFFFFF, 1'b1, 5'd2, 64'h8000000000000000, 5'b00011);
    in_wb_ready = 1'b1;
    idle(3);
    // fill past capacity with SP special cases
    in_wb_ready = 1'b0;
    enq(64'hFFFFFFFF7F800000, 1'b0, 5'd10, 64'hFFFFFFFF7F800000, 5'b00101);
    enq(64'hFFFFFFFF80000001, 1'b0, 5'd11, 64'hFFFFFFFF80000000, 5'b00011);
    enq(64'hFFFFFFFF7FC00001, 1'b0, 5'd12, 64'hFFFFFFFF7FC00000, 5'b00000);
    enq(64'hFFFFFFFF7F800001, 1'b0, 5'd13, 64'hFFFFFFFF7FC00000, 5'b10000);
    chk("full_count", 64'(out_count), 64'd4);
    chk("full_ready", 64'(out_ready), 64'h0);
    enq(64'h3FF0000000000000, 1'b1, 5'd14, 64'h3FF0000000000000, 5'b00000);
    chk("fifth_rejected", 64'(out_count), 64'd4);
    // full with valid and ready together: dequeue only, then both
    in_wb_ready = 1'b1;
    tick();
    chk("full_deq_only", 64'(out_count), 64'd3);
    tick();
    chk("enq_deq_hold", 64'(out_count), 64'd3);
    idle(4);
    chk("drained", 64'(out_count), 64'd0);
    // DP infinity and signalling NaN, then reset mid-operation
    in_wb_ready = 1'b0;
    enq(64'h7FF0000000000000, 1'b1, 5'd20, 64'h7FF0000000000000, 5'b00101);
    chk("inf_flags", 64'(out_wb_flags), 64'(5'b00101));
    enq(64'h7FF0000000000001, 1'b1, 5'd21, 64'h7FF8000000000000, 5'b10000);
    chk("snan_count", 64'(out_count), 64'd2);
    in_valid = 1'b0;
    in_wb_ready = 1'b1;
    in_rst_n = 1'b0;
    tick();
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_fflags", 64'(out_fflags), 64'd0);
    chk("mid_rst_valid", 64'(out_wb_valid), 64'd0);
    in_rst_n = 1'b1;
    enq(64'hC000000000000000, 1'b1, 5'd31, 64'hC000000000000000, 5'b00000);
    chk("post_rst_enq", 64'(out_count), 64'd1);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
